inertial_delay_ctrl: RTL

- Clocked, synthesizable controller that reproduces inertial-delay (pulse-rejecting) behaviour on the AND of two inputs `ai & bi`.
- A runtime-programmable cycle count replaces the fixed `#N` continuous-assign delays.
- Sits between raw request/enable inputs and downstream logic that must ignore short glitches.
- Supplies a registered undelayed copy, the filtered output, a status flag and a dropped-pulse counter.

---
 rtl/inertial_delay_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/inertial_delay_ctrl.sv
// rtl/inertial_delay_ctrl.sv - clocked inertial-delay filter on ai & bi (optional INERTIAL_TRANSPORT_EN adds so_transport)
module inertial_delay_ctrl #(
  parameter int DLY_W       = 8,
  parameter int DEFAULT_DLY = 20,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ai,
  input  logic             bi,
  input  logic             cfg_valid,
  input  logic [DLY_W-1:0] cfg_dly,
  output logic             cfg_ready,
  output logic             so_normal,
  output logic             so_inertial,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
`ifdef INERTIAL_TRANSPORT_EN
  ,
  output logic             so_transport
`endif
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             so_normal_q;
  logic             so_inertial_q, so_inertial_d;

  assign so_normal   = so_normal_q;
  assign so_inertial = so_inertial_q;
  assign drop_cnt    = drop_q;
  assign busy        = (state_q == COUNT);
  // Delay may only change while nothing is pending, so a qualification never sees a new value.
  assign cfg_ready   = (state_q == IDLE) && (so_normal_q == so_inertial_q);

  // State registers and the undelayed datapath copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dly_q         <= DLY_W'(DEFAULT_DLY);
      drop_q        <= '0;
      so_normal_q   <= 1'b0;
      so_inertial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      drop_q        <= drop_d;
      so_normal_q   <= ai & bi;
      so_inertial_q <= so_inertial_d;
    end
  end

  // Qualify each so_normal level change for dly_q+1 stable cycles; shorter pulses are counted as dropped.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dly_d         = dly_q;
    drop_d        = drop_q;
    so_inertial_d = so_inertial_q;
    case (state_q)
      IDLE: begin
        if (so_normal_q != so_inertial_q) begin
          if (dly_q == '0) begin
            so_inertial_d = so_normal_q;
          end else begin
            state_d = COUNT;
            cnt_d   = DLY_W'(1);
          end
        end
      end
      COUNT: begin
        if (so_normal_q == so_inertial_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + 1'b1;
        end else if (cnt_q == dly_q) begin
          so_inertial_d = so_normal_q;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (cfg_valid && cfg_ready) dly_d = cfg_dly;
  end

`ifdef INERTIAL_TRANSPORT_EN
  localparam int TRANS_DEPTH = DEFAULT_DLY + 1;
  logic [TRANS_DEPTH-1:0] trans_q;

  assign so_transport = trans_q[TRANS_DEPTH-1];

  // Fixed-length transport delay line: every pulse survives, however short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trans_q <= '0;
    else     trans_q <= TRANS_DEPTH'({trans_q, so_normal_q});
  end
`endif

endmodule
